// File: rtl/vj_uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : vj_uart_pkg
// Purpose  : Shared types and constants for the detector's UART return path.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vj_uart_pkg;

   localparam int   BYTES_PER_REC   = 5;
   localparam logic UART_IDLE       = 1'b1;
   localparam int   UART_FRAME_BITS = 10;

   // Records are held already narrowed to the 8-bit fields that go on the wire
   typedef struct packed {
      logic [7:0] face_found;
      logic [7:0] row1;
      logic [7:0] col1;
      logic [7:0] row2;
      logic [7:0] col2;
   } face_rec_t;

   typedef enum logic [1:0] {
      PKT_IDLE     = 2'd0,
      PKT_LOAD     = 2'd1,
      PKT_WAIT_CTS = 2'd2,
      PKT_SEND     = 2'd3
   } pkt_state_t;

   typedef enum logic [1:0] {
      BYTE_IDLE  = 2'd0,
      BYTE_START = 2'd1,
      BYTE_DATA  = 2'd2,
      BYTE_STOP  = 2'd3
   } byte_state_t;

   // Byte k of a packet, in the order the laptop-side receiver decodes it
   function automatic logic [7:0] rec_byte(input face_rec_t rec, input logic [2:0] k);
      case (k)
         3'd0:    rec_byte = rec.face_found;
         3'd1:    rec_byte = rec.col1;
         3'd2:    rec_byte = rec.row1;
         3'd3:    rec_byte = rec.col2;
         default: rec_byte = rec.row2;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
//------------------------------------------------------------------------------
// Module   : uart_byte_tx
// Purpose  : 8N1 byte serializer with registered line output; each bit is
//            held BAUD_DIV cycles and done pulses on the last STOP cycle.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_byte_tx
   import vj_uart_pkg::*;
#(
   parameter int BAUD_DIV = 54
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done,
   output logic       idle
);

   localparam int               CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]       C_BIT_LAST = 3'(UART_FRAME_BITS - 3);

   byte_state_t      r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [2:0]       r_bit, w_bit_n;
   logic [7:0]       r_shift, w_shift_n;
   logic             r_tx, w_tx_n;
   logic             w_done;
   logic             w_last;

   assign w_last = (r_cnt == C_CNT_LAST);

   // State, baud counter, bit index, shift register and line flop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= BYTE_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= UART_IDLE;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
         r_tx    <= w_tx_n;
      end
   end

   // Next-state logic; the line value for the next bit is computed one cycle early
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_tx_n    = r_tx;
      w_done    = 1'b0;
      case (r_state)
         BYTE_IDLE: begin
            w_tx_n = UART_IDLE;
            if (start) begin
               w_state_n = BYTE_START;
               w_cnt_n   = '0;
               w_shift_n = data;
               w_tx_n    = 1'b0;
            end
         end
         BYTE_START: begin
            if (w_last) begin
               w_state_n = BYTE_DATA;
               w_cnt_n   = '0;
               w_bit_n   = '0;
               w_tx_n    = r_shift[0];
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end
         BYTE_DATA: begin
            if (w_last) begin
               w_cnt_n = '0;
               if (r_bit == C_BIT_LAST) begin
                  w_state_n = BYTE_STOP;
                  w_tx_n    = UART_IDLE;
               end else begin
                  w_bit_n   = r_bit + 3'd1;
                  w_shift_n = r_shift >> 1;
                  w_tx_n    = r_shift[1];
               end
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end
         BYTE_STOP: begin
            if (w_last) begin
               w_done    = 1'b1;
               w_state_n = BYTE_IDLE;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_n = BYTE_IDLE;
      endcase
   end

   assign tx   = r_tx;
   assign done = w_done;
   assign idle = (r_state == BYTE_IDLE);

endmodule

`default_nettype wire

// File: rtl/face_result_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : face_result_uart_tx
// Purpose  : Buffers face-result records in a FIFO and sends each one as a
//            5-byte 8N1 packet, pausing between bytes while CTS is low.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module face_result_uart_tx
   import vj_uart_pkg::*;
#(
   parameter int BAUD_DIV   = 54,
   parameter int FIFO_DEPTH = 4,
   parameter int COORD_W    = 8
)(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        rec_valid,
   output logic                        rec_ready,
   input  logic [COORD_W-1:0]          rec_face_found,
   input  logic [COORD_W-1:0]          rec_row1,
   input  logic [COORD_W-1:0]          rec_col1,
   input  logic [COORD_W-1:0]          rec_row2,
   input  logic [COORD_W-1:0]          rec_col2,
   input  logic                        uart_cts,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       C_K_LAST = 3'(BYTES_PER_REC - 1);

   face_rec_t        r_mem [FIFO_DEPTH];
   face_rec_t        w_push_rec;
   face_rec_t        r_pkt;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push, w_pop;
   logic             r_cts_meta, r_cts_s;
   pkt_state_t       r_state, w_state_n;
   logic [2:0]       r_k, w_k_n;
   logic             w_start;
   logic             w_byte_done, w_byte_idle;

   // Only the low 8 bits of each field are ever transmitted
   assign w_push_rec.face_found = 8'(rec_face_found);
   assign w_push_rec.row1       = 8'(rec_row1);
   assign w_push_rec.col1       = 8'(rec_col1);
   assign w_push_rec.row2       = 8'(rec_row2);
   assign w_push_rec.col2       = 8'(rec_col2);

   assign rec_ready  = (r_count != C_FULL);
   assign w_push     = rec_valid && rec_ready;
   assign fifo_count = r_count;
   assign busy       = (r_count != '0) || (r_state != PKT_IDLE);

   // CTS arrives from the laptop asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cts_meta <= 1'b0;
         r_cts_s    <= 1'b0;
      end else begin
         r_cts_meta <= uart_cts;
         r_cts_s    <= r_cts_meta;
      end
   end

   // Record storage; contents are don't-care until the count says otherwise
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_rec;
   end

   // FIFO pointers wrap naturally; the count's extra bit separates full from empty
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Packet FSM state, byte index and the record currently being sent
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= PKT_IDLE;
         r_k     <= '0;
         r_pkt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_k     <= w_k_n;
         if (w_pop) r_pkt <= r_mem[r_rd_ptr];
      end
   end

   // CTS is only consulted before a byte starts, so a byte in flight always completes
   always_comb begin
      w_state_n = r_state;
      w_k_n     = r_k;
      w_pop     = 1'b0;
      w_start   = 1'b0;
      case (r_state)
         PKT_IDLE: begin
            if (r_count != '0) begin
               w_pop     = 1'b1;
               w_k_n     = '0;
               w_state_n = PKT_LOAD;
            end
         end
         PKT_LOAD: w_state_n = PKT_WAIT_CTS;
         PKT_WAIT_CTS: begin
            if (r_cts_s && w_byte_idle) begin
               w_start   = 1'b1;
               w_state_n = PKT_SEND;
            end
         end
         PKT_SEND: begin
            if (w_byte_done) begin
               if (r_k == C_K_LAST) begin
                  w_state_n = PKT_IDLE;
               end else begin
                  w_k_n     = r_k + 3'd1;
                  w_state_n = PKT_WAIT_CTS;
               end
            end
         end
         default: w_state_n = PKT_IDLE;
      endcase
   end

   uart_byte_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_byte_tx (
      .clock (clock),
      .reset (reset),
      .start (w_start),
      .data  (rec_byte(r_pkt, r_k)),
      .tx    (uart_tx),
      .done  (w_byte_done),
      .idle  (w_byte_idle)
   );

endmodule

`default_nettype wire

// File: tb/tb_face_result_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_face_result_uart_tx
// Purpose  : Self-checking bench: a behavioural 8N1 receiver decodes the line
//            and is compared against a byte queue built from pushed records.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_face_result_uart_tx;

   localparam int B       = 4;
   localparam int PKT_CYC = 5 * 10 * B + 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       rec_valid, rec_ready, uart_cts, uart_tx, busy;
   logic [7:0] ff, r1, c1, r2, c2;
   logic [2:0] fifo_count;

   logic       v54, ready54, cts54, tx54, busy54;
   logic [7:0] ff54, r1_54, c1_54, r2_54, c2_54;
   logic [2:0] count54;

   int errors = 0;
   int checks = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         rx_active = 1'b0;
   int         rx_cnt;
   logic [7:0] rx_byte;

   face_result_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(4), .COORD_W(8)) dut (
      .clock(clock), .reset(reset), .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_face_found(ff), .rec_row1(r1), .rec_col1(c1), .rec_row2(r2), .rec_col2(c2),
      .uart_cts(uart_cts), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count));

   face_result_uart_tx #(.BAUD_DIV(54), .FIFO_DEPTH(4), .COORD_W(8)) dut54 (
      .clock(clock), .reset(reset), .rec_valid(v54), .rec_ready(ready54),
      .rec_face_found(ff54), .rec_row1(r1_54), .rec_col1(c1_54), .rec_row2(r2_54), .rec_col2(c2_54),
      .uart_cts(cts54), .uart_tx(tx54), .busy(busy54), .fifo_count(count54));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference byte order of one record on the wire
   task automatic model_push(input logic [7:0] f, input logic [7:0] row1, input logic [7:0] col1,
                             input logic [7:0] row2, input logic [7:0] col2);
      exp_q.push_back(f);
      exp_q.push_back(col1);
      exp_q.push_back(row1);
      exp_q.push_back(col2);
      exp_q.push_back(row2);
   endtask

   task automatic push_rec(input logic [7:0] f, input logic [7:0] row1, input logic [7:0] col1,
                           input logic [7:0] row2, input logic [7:0] col2);
      rec_valid = 1'b1;
      ff = f; r1 = row1; c1 = col1; r2 = row2; c2 = col2;
      tick();
      rec_valid = 1'b0;
      model_push(f, row1, col1, row2, col2);
   endtask

   task automatic push_rand();
      push_rec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic compare_bytes(input string tag);
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         tick();
         n++;
      end
      check("idle_timeout", busy, 0);
      repeat (2) tick();
   endtask

   // Expected line level i cycles into a frame carrying byte d
   function automatic logic line_level(input logic [7:0] d, input int i);
      int bitn;
      bitn = i / B;
      if (bitn == 0)      return 1'b0;
      else if (bitn <= 8) return d[bitn-1];
      else                return 1'b1;
   endfunction

   // Behavioural mid-bit sampling receiver on the main DUT's line
   always @(negedge clock) begin
      if (reset) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (uart_tx === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % B == B / 2) begin : sample
            int j;
            j = rx_cnt / B;
            if (j == 0) begin
               check("rx_start_bit", uart_tx, 0);
            end else if (j <= 8) begin
               rx_byte[j-1] = uart_tx;
            end else begin
               check("rx_stop_bit", uart_tx, 1);
               rx_q.push_back(rx_byte);
               rx_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int   n;
      bit   allhigh;
      logic acc;
      int   fill_cnt[5] = '{1, 1, 2, 3, 4};

      reset = 1'b1; rec_valid = 1'b0; uart_cts = 1'b0;
      ff = '0; r1 = '0; c1 = '0; r2 = '0; c2 = '0;
      v54 = 1'b0; cts54 = 1'b1;
      ff54 = '0; r1_54 = '0; c1_54 = '0; r2_54 = '0; c2_54 = '0;
      repeat (3) tick();
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", rec_ready, 1);
      reset = 1'b0;
      uart_cts = 1'b1;
      repeat (4) tick();

      // Full-rate divisor: 3-cycle start latency and 2704-cycle packet
      check("d54_ready", ready54, 1);
      v54 = 1'b1; ff54 = 8'd1; c1_54 = 8'd10; r1_54 = 8'd20; c2_54 = 8'd40; r2_54 = 8'd50;
      tick();
      v54 = 1'b0;
      check("d54_count", count54, 1);
      tick(); check("d54_lat_e1", tx54, 1);
      tick(); check("d54_lat_e2", tx54, 1);
      tick(); check("d54_start", tx54, 0);
      n = 0;
      while (busy54 && n < 3000) begin
         tick();
         n++;
      end
      check("d54_pkt_cycles", n, 2704);

      // Framing of byte A5, inter-byte gap and packet length
      push_rec(8'hA5, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      check("a_count", fifo_count, 1);
      tick(); check("a_lat_e1", uart_tx, 1);
      tick(); check("a_lat_e2", uart_tx, 1);
      tick(); check("a_start_lat", uart_tx, 0);
      for (int i = 0; i < 10 * B; i++) begin
         check($sformatf("a_frame_c%0d", i), uart_tx, line_level(8'hA5, i));
         tick();
      end
      check("a_gap_high", uart_tx, 1);
      tick();
      check("a_next_start", uart_tx, 0);
      n = 10 * B + 1;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      check("a_pkt_cycles", n, PKT_CYC);
      repeat (2) tick();
      compare_bytes("pkt_a5");

      // Reference record and random back-to-back records
      push_rec(8'd1, 8'd20, 8'd10, 8'd50, 8'd40);
      wait_idle(400);
      compare_bytes("pkt_ref");
      for (int i = 0; i < 3; i++) push_rand();
      wait_idle(1000);
      compare_bytes("pkt_rand");

      // CTS low holds the line; rising CTS starts 3 cycles later
      uart_cts = 1'b0;
      repeat (3) tick();
      push_rand();
      allhigh = 1'b1;
      repeat (200) begin
         tick();
         if (uart_tx !== 1'b1) allhigh = 1'b0;
      end
      check("cts0_line_high", allhigh, 1);
      check("cts0_busy", busy, 1);
      check("cts0_count", fifo_count, 0);
      uart_cts = 1'b1;
      tick(); check("cts_rise_e1", uart_tx, 1);
      tick(); check("cts_rise_e2", uart_tx, 1);
      tick(); check("cts_rise_start", uart_tx, 0);
      wait_idle(400);
      compare_bytes("pkt_cts");

      // Drop CTS during DATA of byte 2
      push_rand();
      repeat (3) tick();
      check("e_start", uart_tx, 0);
      repeat (2 * (10 * B + 1) + B + 6) tick();
      uart_cts = 1'b0;
      n = 0;
      while (rx_q.size() < 3 && n < 400) begin
         tick();
         n++;
      end
      check("e_three_bytes", rx_q.size(), 3);
      allhigh = 1'b1;
      repeat (150) begin
         tick();
         if (uart_tx !== 1'b1) allhigh = 1'b0;
      end
      check("e_withheld_nbytes", rx_q.size(), 3);
      check("e_line_high", allhigh, 1);
      uart_cts = 1'b1;
      wait_idle(400);
      compare_bytes("pkt_ctsdrop");

      // Fill with CTS low: first record moves into flight, four more fill the FIFO
      uart_cts = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         ff = 8'($urandom); r1 = 8'($urandom); c1 = 8'($urandom);
         r2 = 8'($urandom); c2 = 8'($urandom);
         rec_valid = 1'b1;
         acc = rec_ready;
         check($sformatf("fill_ready%0d", i), acc, (i < 5) ? 1 : 0);
         tick();
         if (acc) begin
            model_push(ff, r1, c1, r2, c2);
            check($sformatf("fill_count%0d", i), fifo_count, fill_cnt[i]);
         end
      end
      rec_valid = 1'b0;
      check("full_count", fifo_count, 4);
      check("full_ready", rec_ready, 0);
      uart_cts = 1'b1;
      n = 0;
      while (!rec_ready && n < 400) begin
         tick();
         n++;
      end
      check("ready_return", rec_ready, 1);
      check("ready_return_count", fifo_count, 3);
      wait_idle(2000);
      compare_bytes("pkt_fifo_order");

      // Reset during the start bit of byte 1 with one record still queued
      push_rand();
      push_rand();
      check("g_count_before", fifo_count, 1);
      repeat (2 + 10 * B + 2) tick();
      check("g_mid_start", uart_tx, 0);
      reset = 1'b1;
      #1;
      check("g_rst_tx", uart_tx, 1);
      check("g_rst_count", fifo_count, 0);
      check("g_rst_busy", busy, 0);
      check("g_rst_ready", rec_ready, 1);
      tick();
      tick();
      reset = 1'b0;
      rx_q.delete();
      exp_q.delete();
      allhigh = 1'b1;
      repeat (150) begin
         tick();
         if (uart_tx !== 1'b1) allhigh = 1'b0;
      end
      check("g_no_residual_line", allhigh, 1);
      check("g_no_residual_bytes", rx_q.size(), 0);
      check("g_idle_busy", busy, 0);
      push_rand();
      wait_idle(400);
      compare_bytes("pkt_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
